// File: rtl/inhibit_arbiter.sv
// Round-robin arbiter driving the active-low enables of an inhibitor bank, with break-before-make dead time.
// Optional tenure timeout is compiled in with `define INHIBIT_ARB_TIMEOUT_EN.
module inhibit_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int GAP      = 1
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           enable_l,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout
);

  localparam int IDW = $clog2(N_REQ);
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  if (N_REQ < 2 || N_REQ > 16 || GAP < 0 || GAP > 15 || MAX_HOLD < 1) begin : g_bad_param
    $error("inhibit_arbiter: parameter out of range");
  end

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] win;
  logic [IDW-1:0] ptr_nxt;
  logic [3:0]     gap_cnt;
  logic           owner_req;
  logic           to_fire;
  logic           tenure_end;

  // First set request at or after the pointer, wrapping; result is only used when |r.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDW-1:0]   p);
    logic found;
    int   j;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(p) + i) % N_REQ;
      if (!found && r[j]) begin
        rr_pick = IDW'(j);
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [N_REQ-1:0] enables_for(input logic [IDW-1:0] k);
    enables_for    = '1;
    enables_for[k] = 1'b0;
  endfunction

  assign win        = rr_pick(req, ptr);
  assign owner_req  = req[owner];
  assign ptr_nxt    = (owner == IDW'(N_REQ - 1)) ? '0 : owner + IDW'(1);
  assign tenure_end = !owner_req || to_fire;

`ifdef INHIBIT_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt;
  logic          timeout_q;

  assign to_fire = (hold_cnt == HW'(MAX_HOLD));
  assign timeout = timeout_q;

  // Hold counter saturates at MAX_HOLD; reaching it ends the tenure regardless of req.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == S_GRANT) && to_fire;
      if (state == S_IDLE && |req)
        hold_cnt <= HW'(1);
      else if (state == S_GRANT && !tenure_end)
        hold_cnt <= hold_cnt + HW'(1);
    end
  end
`else
  assign to_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= S_IDLE;
      ptr      <= '0;
      owner    <= '0;
      gap_cnt  <= '0;
      enable_l <= '1;
      busy     <= 1'b0;
      grant_id <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner    <= win;
            grant_id <= win;
            busy     <= 1'b1;
            enable_l <= enables_for(win);
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (tenure_end) begin
            ptr      <= ptr_nxt;
            enable_l <= '1;
            busy     <= 1'b0;
            grant_id <= '0;
            if (GAP > 0) begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'd0)
            state <= S_IDLE;
          else
            gap_cnt <= gap_cnt - 4'd1;
        end
        default: begin
          state    <= S_IDLE;
          enable_l <= '1;
          busy     <= 1'b0;
          grant_id <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inhibit_arbiter.sv
// Directed bench for inhibit_arbiter: two instances (GAP=1 and GAP=3) share stimulus; a cycle model
// pushes expected outputs to per-instance queues that are popped after each clock edge.
module tb_inhibit_arbiter;

`ifdef INHIBIT_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int MH = 4;

  typedef struct {
    logic [3:0] en;
    logic       busy;
    logic [1:0] gid;
    logic       to;
  } exp_t;

  logic       clk;
  logic       reset_l;
  logic [3:0] req;
  logic [3:0] en0, en1;
  logic [1:0] gid0, gid1;
  logic       busy0, busy1, to0, to1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state per instance: 0 idle, 1 grant, 2 gap
  int ms[2], mp[2], mo[2], mg[2], mh[2];
  logic mt[2];
  int gapv[2] = '{1, 3};

  inhibit_arbiter #(.N_REQ(4), .MAX_HOLD(MH), .GAP(1)) u_dut (
    .clk(clk), .reset_l(reset_l), .req(req),
    .enable_l(en0), .grant_id(gid0), .busy(busy0), .timeout(to0));

  inhibit_arbiter #(.N_REQ(4), .MAX_HOLD(MH), .GAP(3)) u_gap3 (
    .clk(clk), .reset_l(reset_l), .req(req),
    .enable_l(en1), .grant_id(gid1), .busy(busy1), .timeout(to1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ms[d] = 0; mp[d] = 0; mo[d] = 0; mg[d] = 0; mh[d] = 0; mt[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input logic [3:0] r);
    bit fire;
    bit found;
    int idx;
    mt[d] = 1'b0;
    case (ms[d])
      0: if (r != 4'b0) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          idx = (mp[d] + k) % 4;
          if (!found && r[idx]) begin
            mo[d] = idx;
            found = 1;
          end
        end
        ms[d] = 1;
        mh[d] = 1;
      end
      1: begin
        fire = TO_EN && (mh[d] == MH);
        if (!r[mo[d]] || fire) begin
          mt[d] = fire;
          mp[d] = (mo[d] + 1) % 4;
          if (gapv[d] > 0) begin
            ms[d] = 2;
            mg[d] = gapv[d];
          end else begin
            ms[d] = 0;
          end
        end else if (mh[d] < MH) begin
          mh[d]++;
        end
      end
      default: begin
        mg[d]--;
        if (mg[d] == 0) ms[d] = 0;
      end
    endcase
  endtask

  function automatic exp_t model_out(input int d);
    exp_t e;
    e.busy = (ms[d] == 1);
    e.gid  = e.busy ? 2'(mo[d]) : 2'd0;
    e.en   = 4'hF;
    if (e.busy) e.en[mo[d]] = 1'b0;
    e.to   = mt[d];
    return e;
  endfunction

  // Drive one cycle of req, predict, then compare both instances after the edge.
  task automatic step(input logic [3:0] r);
    exp_t e;
    req = r;
    model_step(0, r);
    model_step(1, r);
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
    @(posedge clk);
    #1;
    e = q0.pop_front();
    chk("g1_enable_l", 32'(en0), 32'(e.en));
    chk("g1_busy", 32'(busy0), 32'(e.busy));
    chk("g1_grant_id", 32'(gid0), 32'(e.gid));
    chk("g1_timeout", 32'(to0), 32'(e.to));
    e = q1.pop_front();
    chk("g3_enable_l", 32'(en1), 32'(e.en));
    chk("g3_busy", 32'(busy1), 32'(e.busy));
    chk("g3_grant_id", 32'(gid1), 32'(e.gid));
    chk("g3_timeout", 32'(to1), 32'(e.to));
    chk("g1_onehot", 32'($countones(~en0) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    req = 4'b0;
    @(posedge clk);
    #1;
    reset_l = 1'b1;
    model_reset();
  endtask

  initial begin
    int order[$];
    int hi_cnt;
    int tenures;
    int own0;
    bit to_seen;
    logic prev_busy;

    reset_l = 1'b0;
    req = 4'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enable_l", 32'(en0), 32'hF);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_grant_id", 32'(gid0), 32'd0);
    chk("rst_timeout", 32'(to0), 32'd0);
    chk("rst_g3_enable_l", 32'(en1), 32'hF);
    reset_l = 1'b1;

    // Single requester for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(4'b0100);
      chk("single_enable_l", 32'(en0), 32'hB);
      chk("single_grant_id", 32'(gid0), 32'd2);
    end
    step(4'b0000);
    chk("single_release", 32'(en0), 32'hF);
    repeat (3) step(4'b0000);

    // Round robin with all requests high; owner drops after 2 granted cycles
    do_reset();
    tenures = 0; hi_cnt = 0; prev_busy = 1'b0;
    for (int n = 0; n < 60 && tenures < 5; n++) begin
      logic [3:0] r;
      r = 4'hF;
      if (ms[0] == 1 && mh[0] >= 2) r[mo[0]] = 1'b0;
      step(r);
      if (busy0 && !prev_busy) begin
        order.push_back(int'(gid0));
        if (tenures > 0) chk("rr_dead_cycles", 32'(hi_cnt), 32'd2);
        tenures++;
        hi_cnt = 0;
      end
      if (en0 == 4'hF) hi_cnt++;
      prev_busy = busy0;
    end
    chk("rr_tenures", 32'(tenures), 32'd5);
    for (int i = 0; i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(i % 4));

    // Gap timing on the GAP=3 instance
    do_reset();
    step(4'b0001);
    chk("gap_owner0", 32'(en1), 32'hE);
    step(4'b0011);
    step(4'b0010);
    hi_cnt = 0;
    for (int n = 0; n < 10 && en1 == 4'hF; n++) begin
      hi_cnt++;
      if (n == 0 || en1 == 4'hF) step(4'b0010);
    end
    for (int n = 0; n < 10 && en1 == 4'hF; n++) begin
      hi_cnt++;
      step(4'b0010);
    end
    chk("gap_high_edges", 32'(hi_cnt), 32'd4);
    chk("gap_next_grant", 32'(en1), 32'hD);

    // Timeout behaviour with req=0011 held
    do_reset();
    own0 = 0; to_seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step(4'b0011);
      if (busy0 && gid0 == 2'd0 && !to_seen) own0++;
      if (to0) to_seen = 1'b1;
      if (to_seen && busy0) break;
    end
`ifdef INHIBIT_ARB_TIMEOUT_EN
    chk("to_owner0_cycles", 32'(own0), 32'd4);
    chk("to_pulse_seen", 32'(to_seen), 32'd1);
    chk("to_next_owner", 32'(gid0), 32'd1);
`else
    chk("to_owner0_holds", 32'(en0), 32'hE);
    chk("to_never_pulses", 32'(to_seen), 32'd0);
`endif

    // No preemption; pointer wraps from owner 3 to 0
    do_reset();
    step(4'b1000);
    for (int i = 0; i < 3; i++) begin
      step(4'b1001);
      chk("nopre_enable_l", 32'(en0), 32'h7);
    end
    step(4'b0001);
    chk("nopre_release", 32'(en0), 32'hF);
    step(4'b0001);
    step(4'b0001);
    chk("nopre_wrap_grant", 32'(gid0), 32'd0);
    chk("nopre_wrap_enable", 32'(en0), 32'hE);

    // Asynchronous reset mid-tenure
    repeat (3) step(4'b0000);
    step(4'b0100);
    chk("amid_enable_l", 32'(en0), 32'hB);
    #2;
    reset_l = 1'b0;
    #1;
    chk("async_enable_l", 32'(en0), 32'hF);
    chk("async_busy", 32'(busy0), 32'd0);
    chk("async_grant_id", 32'(gid0), 32'd0);
    req = 4'b0;
    @(posedge clk);
    #1;
    reset_l = 1'b1;
    model_reset();
    step(4'b0010);
    chk("post_rst_grant", 32'(gid0), 32'd1);
    chk("post_rst_enable", 32'(en0), 32'hD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
